// File: rtl/guess_entry_if.sv
// Signal bundle between the switch/button front end (guess_entry) and whatever drives it and consumes the accepted guesses.
`timescale 1ns/1ps
interface guess_entry_if;
    logic [4:0]  letter_sw;
    logic        key_n;
    logic        clear;
    logic [4:0]  guess;
    logic        go;
    logic        busy;
    logic        repeat_err;
    logic        invalid_err;
    logic [25:0] used_mask;
    logic [4:0]  guess_count;

    modport master (
        output letter_sw, key_n, clear,
        input  guess, go, busy, repeat_err, invalid_err, used_mask, guess_count
    );

    modport slave (
        input  letter_sw, key_n, clear,
        output guess, go, busy, repeat_err, invalid_err, used_mask, guess_count
    );
endinterface

// File: rtl/guess_entry.sv
// Hangman guess entry: synchronizes the push-button, validates the switch letter and strobes go per accepted guess.
// Optional key debounce filter is compiled in with `define GUESS_ENTRY_DEBOUNCE_EN.
`timescale 1ns/1ps
module guess_entry #(
    parameter int GO_CYCLES       = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          resetn,
    guess_entry_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_WAIT_RELEASE
    } state_t;

    localparam logic [3:0] GO_LAST   = 4'(GO_CYCLES - 1);
    localparam logic [4:0] MAX_COUNT = 5'd26;

    if (GO_CYCLES < 1 || GO_CYCLES > 15 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_param_err
        $error("guess_entry: parameter out of legal range");
    end

    state_t      state_q, state_d;
    logic [3:0]  go_cnt_q, go_cnt_d;
    logic [4:0]  guess_q, guess_d;
    logic [25:0] mask_q, mask_d;
    logic [4:0]  count_q, count_d;
    logic        rep_err_q, rep_err_d;
    logic        inv_err_q, inv_err_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic        key_lvl;
    logic        press;

    always_comb begin
        sync1_d = bus.key_n;
        sync2_d = sync1_q;
        prev_d  = key_lvl;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef GUESS_ENTRY_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        filt_q, filt_d;
    logic [15:0] db_cnt_q, db_cnt_d;

    // Counter runs only while the synchronized level disagrees with the filtered one; any agreement restarts it.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = 16'd0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt_q   <= 1'b1;
            db_cnt_q <= 16'd0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign key_lvl = filt_q;
`else
    assign key_lvl = sync2_q;
`endif

    assign press = prev_q & ~key_lvl;

    always_comb begin
        state_d   = state_q;
        go_cnt_d  = go_cnt_q;
        guess_d   = guess_q;
        mask_d    = mask_q;
        count_d   = count_q;
        rep_err_d = 1'b0;
        inv_err_d = 1'b0;
        // Clear wins over everything, including a press seen in the same cycle.
        if (bus.clear) begin
            state_d  = S_IDLE;
            go_cnt_d = 4'd0;
            mask_d   = 26'd0;
            count_d  = 5'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (press) begin
                        if (bus.letter_sw >= 5'd26) begin
                            inv_err_d = 1'b1;
                            state_d   = S_WAIT_RELEASE;
                        end else if (mask_q[bus.letter_sw]) begin
                            rep_err_d = 1'b1;
                            state_d   = S_WAIT_RELEASE;
                        end else begin
                            guess_d                = bus.letter_sw;
                            mask_d[bus.letter_sw]  = 1'b1;
                            if (count_q < MAX_COUNT) begin
                                count_d = count_q + 5'd1;
                            end
                            go_cnt_d = GO_LAST;
                            state_d  = S_GO;
                        end
                    end
                end
                S_GO: begin
                    if (go_cnt_q == 4'd0) begin
                        state_d = S_WAIT_RELEASE;
                    end else begin
                        go_cnt_d = go_cnt_q - 4'd1;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (key_lvl) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            go_cnt_q  <= 4'd0;
            guess_q   <= 5'd0;
            mask_q    <= 26'd0;
            count_q   <= 5'd0;
            rep_err_q <= 1'b0;
            inv_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_cnt_q  <= go_cnt_d;
            guess_q   <= guess_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            rep_err_q <= rep_err_d;
            inv_err_q <= inv_err_d;
        end
    end

    // go is decoded from the state register so an asynchronous reset drops it immediately.
    assign bus.go          = (state_q == S_GO);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.guess       = guess_q;
    assign bus.used_mask   = mask_q;
    assign bus.guess_count = count_q;
    assign bus.repeat_err  = rep_err_q;
    assign bus.invalid_err = inv_err_q;

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL have parameter GO_CYCLES, default 4: number of clk cycles go is held high per accepted guess (legal range 1..15).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: stability window used only when debounce is compiled in (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port letter_sw, input, 5 bits: letter code from switches (0=A .. 25=Z), assumed static while key_n is pressed.
REQ-006 SHALL have port key_n, input, 1 bit: asynchronous push-button, low = pressed.
REQ-007 SHALL have port clear, input, 1 bit: synchronous new-game clear.
REQ-008 SHALL have port guess, output, 5 bits: last accepted letter code, presented to the letter-check controller.
REQ-009 SHALL have port go, output, 1 bit: guess-valid strobe for the letter-check controller.
REQ-010 SHALL have port busy, output, 1 bit: high while not in S_IDLE.
REQ-011 SHALL have port repeat_err, output, 1 bit: one-cycle pulse when an already-guessed letter is rejected.
REQ-012 SHALL have port invalid_err, output, 1 bit: one-cycle pulse when a code of 26..31 is rejected.
REQ-013 SHALL have port used_mask, output, 26 bits: bit n set once letter n has been accepted.
REQ-014 SHALL have port guess_count, output, 5 bits: number of accepted guesses.

Function
REQ-015 SHALL pass key_n through a 2-flop synchronizer; the press event is the synchronized (or filtered) level going 1->0 relative to its previous-cycle value.
REQ-016 SHALL implement states S_IDLE, S_GO and S_WAIT_RELEASE.
REQ-017 In S_IDLE, a press event with letter_sw >= 26 SHALL pulse invalid_err for 1 cycle and go to S_WAIT_RELEASE.
REQ-018 In S_IDLE, a press event with used_mask[letter_sw]=1 SHALL pulse repeat_err for 1 cycle and go to S_WAIT_RELEASE.
REQ-019 In S_IDLE, any other press event SHALL register guess<=letter_sw, set used_mask[letter_sw], increment guess_count, and go to S_GO.
REQ-020 In S_GO, go SHALL be high for exactly GO_CYCLES consecutive cycles, then the block SHALL go to S_WAIT_RELEASE with go low.
REQ-021 In S_WAIT_RELEASE, the block SHALL return to S_IDLE once the synchronized or filtered key is high.
REQ-022 Press events outside S_IDLE SHALL be ignored.
REQ-023 guess SHALL stay stable from acceptance until the next accepted guess.
REQ-024 Without debounce, go SHALL first be high in the cycle after the 3rd rising clk edge at which key_n is sampled low.
REQ-025 guess_count SHALL saturate at 26.
REQ-026 used_mask and guess_count SHALL be updated only on acceptance.
REQ-027 clear SHALL zero used_mask and guess_count, drop go and move to S_IDLE on the next edge, regardless of state.
REQ-028 clear SHALL take priority over a press event in the same cycle; that press is discarded and neither err pulse fires.
REQ-029 When a mask update and clear coincide, the result SHALL be mask=0.

Reset
REQ-030 resetn low SHALL asynchronously force: state S_IDLE; guess=0; go=0; busy=0; repeat_err=0; invalid_err=0; used_mask=0; guess_count=0.
REQ-031 resetn low SHALL also force the synchronizer flops, previous-level flop and debounce state to 1 (released).
REQ-032 Reset asserted mid-S_GO SHALL drop go immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro GUESS_ENTRY_DEBOUNCE_EN defined: the synchronized key SHALL hold a new level for DEBOUNCE_CYCLES consecutive cycles before the filtered level changes; shorter glitches are rejected; latency grows by DEBOUNCE_CYCLES cycles.
REQ-034 Macro GUESS_ENTRY_DEBOUNCE_EN undefined: no filter; the filtered level SHALL equal the synchronized level.

Verification
REQ-035 Scenario: letter_sw=18, key_n held low 10 cycles, GO_CYCLES=4 (no debounce) -> go high 4 cycles starting after the 3rd edge; guess=18; used_mask=0x0040000; guess_count=1.
REQ-036 Scenario: press 18 again after release -> repeat_err 1-cycle pulse; no go; guess_count stays 1.
REQ-037 Scenario: letter_sw=27, press -> invalid_err pulse; used_mask and guess_count unchanged.
REQ-038 Scenario: second press during S_GO -> ignored; exactly 4 go cycles total.
REQ-039 Scenario: clear asserted in the same cycle as a press event -> used_mask=0, guess_count=0, no go, no err.
REQ-040 Scenario: GUESS_ENTRY_DEBOUNCE_EN with DEBOUNCE_CYCLES=16 -> 5-cycle low glitch gives no go; a 40-cycle press gives exactly one go burst.
